// File: rtl/round_seq_pkg.sv
// Shared encodings for the round sequencer: FSM state codes and the level
// codes driven onto the countdown timer's flag input.
package round_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_LOAD  = 3'd2,
      S_RUN   = 3'd3,
      S_PAUSE = 3'd4,
      S_NEXT  = 3'd5,
      S_OVER  = 3'd6,
      S_WIN   = 3'd7
   } state_t;

   // Flag code 0 arms a timer reload; levels run 1..3 and go out unencoded.
   localparam logic [2:0] FLAG_RELOAD = 3'd0;
   localparam logic [2:0] LEVEL_FIRST = 3'd1;
   localparam logic [2:0] LEVEL_LAST  = 3'd3;

   function automatic logic [2:0] next_level(input logic [2:0] lvl);
      return lvl + 3'd1;
   endfunction

endpackage

// File: rtl/round_seq.sv
// Round sequencer: steps a game through arm/load/run/pause/next-level/over/win
// and drives the countdown timer's level select and run-latch toggle.
module round_seq
   import round_seq_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int MAX_LEVEL  = int'(LEVEL_LAST)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_start,
   input  logic       key_pause,
   input  logic       snake_dead,
   input  logic       level_done,
   input  logic       time_up,
   output logic [2:0] flag,
   output logic       start_stop,
   output logic       tone_en,
   output logic       running,
   output logic       game_over,
   output logic       win,
   output logic [2:0] state
);

   localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

   state_t           state_q, state_d;
   logic [2:0]       flag_q, flag_d;
   logic [2:0]       level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_stop_q, start_stop_d;
   logic             running_q, running_d;
   logic             game_over_q, game_over_d;
   logic             win_q, win_d;
   logic             tone_en_q, tone_en_d;
   logic             pulse_ok;

   always_comb begin
      state_d      = state_q;
      flag_d       = flag_q;
      level_d      = level_q;
      cnt_d        = cnt_q;
      start_stop_d = 1'b0;
      running_d    = running_q;
      game_over_d  = game_over_q;
      win_d        = win_q;
      tone_en_d    = 1'b1;
      // A toggle on the output this cycle blocks any toggle in the next one.
      pulse_ok     = !start_stop_q;

      case (state_q)
         S_IDLE: begin
            if (key_start) state_d = S_ARM;
         end
         S_ARM: begin
            // First ARM cycle drives the reload code, second restores level 1.
            if (flag_q != FLAG_RELOAD) begin
               flag_d = FLAG_RELOAD;
            end else begin
               flag_d  = LEVEL_FIRST;
               level_d = LEVEL_FIRST;
               cnt_d   = CNT_W'(SETTLE_CYC);
               state_d = S_LOAD;
            end
         end
         S_LOAD, S_NEXT: begin
            if (cnt_q <= CNT_W'(1) && pulse_ok) begin
               start_stop_d = !running_q;
               running_d    = 1'b1;
               state_d      = S_RUN;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RUN: begin
            if (pulse_ok) begin
               if (snake_dead || time_up) begin
                  start_stop_d = running_q;
                  running_d    = 1'b0;
                  game_over_d  = 1'b1;
                  state_d      = S_OVER;
               end else if (level_done) begin
                  start_stop_d = running_q;
                  running_d    = 1'b0;
                  if (level_q == 3'(MAX_LEVEL)) begin
                     win_d   = 1'b1;
                     state_d = S_WIN;
                  end else begin
                     level_d = next_level(level_q);
                     flag_d  = next_level(level_q);
                     cnt_d   = CNT_W'(SETTLE_CYC);
                     state_d = S_NEXT;
                  end
               end else if (key_pause) begin
                  start_stop_d = running_q;
                  running_d    = 1'b0;
                  state_d      = S_PAUSE;
               end
            end
         end
         S_PAUSE: begin
            // Timer is already stopped, so a collision here needs no toggle.
            if (snake_dead) begin
               game_over_d = 1'b1;
               state_d     = S_OVER;
            end else if ((key_pause || key_start) && pulse_ok) begin
               start_stop_d = !running_q;
               running_d    = 1'b1;
               state_d      = S_RUN;
            end
         end
         S_OVER, S_WIN: begin
            if (key_start) begin
               game_over_d = 1'b0;
               win_d       = 1'b0;
               state_d     = S_ARM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         flag_q       <= LEVEL_FIRST;
         level_q      <= LEVEL_FIRST;
         cnt_q        <= '0;
         start_stop_q <= 1'b0;
         running_q    <= 1'b0;
         game_over_q  <= 1'b0;
         win_q        <= 1'b0;
         tone_en_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         flag_q       <= flag_d;
         level_q      <= level_d;
         cnt_q        <= cnt_d;
         start_stop_q <= start_stop_d;
         running_q    <= running_d;
         game_over_q  <= game_over_d;
         win_q        <= win_d;
         tone_en_q    <= tone_en_d;
      end
   end

   assign flag       = flag_q;
   assign start_stop = start_stop_q;
   assign tone_en    = tone_en_q;
   assign running    = running_q;
   assign game_over  = game_over_q;
   assign win        = win_q;
   assign state      = state_q;

endmodule

// File: tb/tb_round_seq.sv
// Bench for round_seq: directed vector table, hand-written corner sequences,
// and random play checked every cycle against a game-level reference model.
module tb_round_seq;

   localparam int SETTLE = 4;
   localparam int MAXL   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_start = 1'b0, key_pause = 1'b0, snake_dead = 1'b0;
   logic       level_done = 1'b0, time_up = 1'b0;
   logic [2:0] flag, state;
   logic       start_stop, tone_en, running, game_over, win;

   round_seq #(.SETTLE_CYC(SETTLE), .MAX_LEVEL(MAXL)) dut (
      .clk(clk), .rst(rst), .key_start(key_start), .key_pause(key_pause),
      .snake_dead(snake_dead), .level_done(level_done), .time_up(time_up),
      .flag(flag), .start_stop(start_stop), .tone_en(tone_en),
      .running(running), .game_over(game_over), .win(win), .state(state)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [10:0] exp_q[$];

   // Reference model: game phase codes, current level, cycles spent in phase.
   int m_st = 0, m_flag = 1, m_level = 1, m_dwell = 0;
   bit m_ss = 0, m_run = 0, m_go = 0, m_win = 0;

   function automatic logic [10:0] dut_vec();
      return {state, flag, start_stop, running, game_over, win, tone_en};
   endfunction

   function automatic logic [10:0] model_vec();
      return {3'(m_st), 3'(m_flag), m_ss, m_run, m_go, m_win, 1'b1};
   endfunction

   task automatic check(input string name, input logic [10:0] a, input logic [10:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got state=%0d flag=%0d ss=%0b run=%0b go=%0b win=%0b tone=%0b, expected state=%0d flag=%0d ss=%0b run=%0b go=%0b win=%0b tone=%0b",
                  name, a[10:8], a[7:5], a[4], a[3], a[2], a[1], a[0],
                  e[10:8], e[7:5], e[4], e[3], e[2], e[1], e[0]);
      end
   endtask

   // The timer toggles only when the wanted run state differs from its latch.
   task automatic request_run(input bit want);
      if (want != m_run) m_ss = 1'b1;
      m_run = want;
   endtask

   task automatic model_step(input bit r, ks, kp, sd, ld, tu);
      bit busy;
      busy = m_ss;
      m_ss = 1'b0;
      if (!r) begin
         m_st = 0; m_flag = 1; m_level = 1; m_run = 0; m_go = 0; m_win = 0; m_dwell = 0;
      end else begin
         case (m_st)
            0: if (ks) begin m_st = 1; m_dwell = 0; end
            1: begin
               m_dwell++;
               if (m_dwell == 1) m_flag = 0;
               else begin m_flag = 1; m_level = 1; m_dwell = 0; m_st = 2; end
            end
            2, 5: begin
               m_dwell++;
               if (m_dwell >= SETTLE && !busy) begin request_run(1'b1); m_st = 3; end
            end
            3: if (!busy) begin
               if (sd || tu) begin request_run(1'b0); m_go = 1; m_st = 6; end
               else if (ld) begin
                  request_run(1'b0);
                  if (m_level == MAXL) begin m_win = 1; m_st = 7; end
                  else begin m_level++; m_flag = m_level; m_dwell = 0; m_st = 5; end
               end else if (kp) begin request_run(1'b0); m_st = 4; end
            end
            4: begin
               if (sd) begin m_go = 1; m_st = 6; end
               else if ((kp || ks) && !busy) begin request_run(1'b1); m_st = 3; end
            end
            6, 7: if (ks) begin m_go = 0; m_win = 0; m_dwell = 0; m_st = 1; end
            default: ;
         endcase
      end
   endtask

   // Driver: apply inputs for one clock, then compare DUT against the model.
   task automatic step(input bit r, ks, kp, sd, ld, tu);
      rst = r; key_start = ks; key_pause = kp; snake_dead = sd; level_done = ld; time_up = tu;
      @(posedge clk);
      model_step(r, ks, kp, sd, ld, tu);
      exp_q.push_back(model_vec());
      #1;
      check("model", dut_vec(), exp_q.pop_front());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
   endtask

   // From IDLE/OVER/WIN: start, arm, settle, run pulse, then one quiet RUN cycle.
   task automatic go_to_run();
      step(1, 1, 0, 0, 0, 0);
      idle(7);
   endtask

   typedef struct {
      bit r, ks, kp, sd, ld, tu;
      logic [2:0] st, fl;
      bit ss, run, go, wn;
   } vec_t;
   vec_t tbl[$];

   task automatic row(input bit r, ks, kp, sd, ld, tu,
                      input int st, fl, input bit ss, run, go, wn);
      vec_t v;
      v.r = r; v.ks = ks; v.kp = kp; v.sd = sd; v.ld = ld; v.tu = tu;
      v.st = 3'(st); v.fl = 3'(fl); v.ss = ss; v.run = run; v.go = go; v.wn = wn;
      tbl.push_back(v);
   endtask

   initial begin
      // r ks kp sd ld tu | state flag ss run go win
      row(0,0,0,0,0,0, 0,1,0,0,0,0);
      row(1,0,1,1,1,1, 0,1,0,0,0,0);
      row(1,1,0,0,0,0, 1,1,0,0,0,0);
      row(1,0,0,0,0,0, 1,0,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 3,1,1,1,0,0);
      row(1,0,1,0,0,0, 3,1,0,1,0,0);
      row(1,0,1,0,0,0, 4,1,1,0,0,0);
      row(1,0,0,0,1,1, 4,1,0,0,0,0);
      row(1,0,1,0,0,0, 3,1,1,1,0,0);
      row(1,0,0,0,0,0, 3,1,0,1,0,0);
      row(1,0,0,0,1,0, 5,2,1,0,0,0);
      row(1,0,0,0,0,0, 5,2,0,0,0,0);
      row(1,0,0,0,0,0, 5,2,0,0,0,0);
      row(1,0,0,0,0,0, 5,2,0,0,0,0);
      row(1,0,0,0,0,0, 3,2,1,1,0,0);
      row(1,0,0,0,0,0, 3,2,0,1,0,0);
      row(1,0,0,1,1,0, 6,2,1,0,1,0);
      row(1,0,1,0,1,1, 6,2,0,0,1,0);
      row(1,1,0,0,0,0, 1,2,0,0,0,0);
      row(1,0,0,0,0,0, 1,0,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 3,1,1,1,0,0);
      row(1,0,0,0,0,0, 3,1,0,1,0,0);
      row(1,0,0,0,1,0, 5,2,1,0,0,0);
      row(1,0,0,0,0,0, 5,2,0,0,0,0);
      row(1,0,0,0,0,0, 5,2,0,0,0,0);
      row(1,0,0,0,0,0, 5,2,0,0,0,0);
      row(1,0,0,0,0,0, 3,2,1,1,0,0);
      row(1,0,0,0,0,0, 3,2,0,1,0,0);
      row(1,0,0,0,1,0, 5,3,1,0,0,0);
      row(1,0,0,0,0,0, 5,3,0,0,0,0);
      row(1,0,0,0,0,0, 5,3,0,0,0,0);
      row(1,0,0,0,0,0, 5,3,0,0,0,0);
      row(1,0,0,0,0,0, 3,3,1,1,0,0);
      row(1,0,0,0,0,0, 3,3,0,1,0,0);
      row(1,0,0,0,1,0, 7,3,1,0,0,1);
      row(1,0,1,1,1,1, 7,3,0,0,0,1);
      row(1,1,0,0,0,0, 1,3,0,0,0,0);
      row(1,0,0,0,0,0, 1,0,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 2,1,0,0,0,0);
      row(1,0,0,0,0,0, 3,1,1,1,0,0);
      row(1,0,0,0,0,0, 3,1,0,1,0,0);
      row(1,0,0,0,1,0, 5,2,1,0,0,0);
      row(0,0,0,0,0,0, 0,1,0,0,0,0);
      row(1,0,0,0,0,0, 0,1,0,0,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].ks, tbl[i].kp, tbl[i].sd, tbl[i].ld, tbl[i].tu);
         check($sformatf("table row %0d", i), dut_vec(),
               {tbl[i].st, tbl[i].fl, tbl[i].ss, tbl[i].run, tbl[i].go, tbl[i].wn, 1'b1});
      end

      // Reset while running: straight to IDLE with no stop toggle.
      go_to_run();
      step(0, 0, 0, 0, 0, 0);
      check("reset mid-run", dut_vec(), {3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

      // Collision while paused: OVER without a toggle.
      go_to_run();
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      check("pause collision", dut_vec(), {3'd6, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});

      // Restart from OVER, then countdown expiry ends the round.
      go_to_run();
      check("restart from over", dut_vec(), {3'd3, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      step(1, 0, 0, 0, 0, 1);
      check("time up", dut_vec(), {3'd6, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});

      // Random play against the model.
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 299) != 0,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 39) == 0,
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 49) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/round_seq.md
ROUND_SEQ -- requirements
Module: round_seq

Interface
REQ-001 Parameters: SETTLE_CYC, default 4, idle cycles between a flag change and the run pulse.
REQ-002 Parameters: MAX_LEVEL, default 3, highest level, encoded directly on flag.
REQ-003 clk  in  1  system clock; one clock domain.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 key_start  in  1  debounced one-cycle start/resume pulse.
REQ-006 key_pause  in  1  debounced one-cycle pause-toggle pulse.
REQ-007 snake_dead  in  1  one-cycle pulse: snake collision.
REQ-008 level_done  in  1  one-cycle pulse: level target reached.
REQ-009 time_up  in  1  level when countdown reads 0:00.
REQ-010 flag  out  3  level select to countdown timer; 0 = reload-arm code.
REQ-011 start_stop  out  1  one-cycle toggle pulse to timer run latch.
REQ-012 tone_en  out  1  timer enable.
REQ-013 running  out  1  mirror of timer run latch.
REQ-014 game_over, win  out  1 each  terminal status levels.
REQ-015 state  out  3  current FSM state code.

Function
REQ-016 All outputs SHALL be registered; event sampled in cycle N produces its response in cycle N+1.
REQ-017 States: IDLE=0, ARM=1, LOAD=2, RUN=3, PAUSE=4, NEXT=5, OVER=6, WIN=7.
REQ-018 IDLE: key_start -> ARM; other inputs ignored.
REQ-019 ARM: flag=0 for exactly one cycle, then flag=1, level=1 -> LOAD (forces timer reload even when flag was already 1).
REQ-020 LOAD and NEXT: hold flag stable SETTLE_CYC cycles, then pulse start_stop once, running<=1 -> RUN.
REQ-021 RUN priority when coincident: snake_dead > time_up > level_done > key_pause.
REQ-022 RUN: snake_dead or time_up -> stop pulse, running<=0, game_over<=1 -> OVER.
REQ-023 RUN: level_done with level==MAX_LEVEL -> stop pulse, win<=1 -> WIN; else stop pulse, level+1, flag<=level+1 -> NEXT.
REQ-024 RUN: key_pause -> stop pulse -> PAUSE.
REQ-025 PAUSE: key_pause or key_start -> run pulse -> RUN; time_up and level_done ignored; snake_dead -> OVER with no pulse.
REQ-026 OVER/WIN: key_start -> clear game_over/win -> ARM; others ignored.
REQ-027 start_stop SHALL pulse only when the requested run state differs from running; never two pulses in consecutive cycles.
REQ-028 tone_en SHALL be 1 in every state and during reset.
REQ-029 Settle counter width clog2(SETTLE_CYC+1); reloaded on every LOAD/NEXT entry.

Reset
REQ-030 rst low at a clock edge: state=IDLE, flag=1, level=1, start_stop=0, running=0, game_over=0, win=0, tone_en=1, settle counter=0.
REQ-031 Reset mid-RUN SHALL not emit a stop pulse; the timer is reset by the same rst.

Structure
REQ-032 Shared package: state encodings, level codes 1..3, reload-arm code 0.
REQ-033 Single module; settle counter inline, no sub-module.

Verification
REQ-034 Reset, key_start at cycle 10 -> flag 0 in cycle 12, flag 1 from cycle 13, start_stop pulse cycle 17, state=RUN.
REQ-035 RUN, key_pause x2 -> two single pulses, running 1->0->1, flag unchanged.
REQ-036 RUN level 1, level_done -> stop pulse, flag=2, run pulse SETTLE_CYC cycles later; at level 3 -> WIN, win=1.
REQ-037 RUN, snake_dead and level_done same cycle -> OVER, game_over=1, flag unchanged, exactly one pulse.
REQ-038 OVER at flag=1, key_start -> flag 0 then 1, game_over cleared, run pulse after settle.
REQ-039 rst asserted in NEXT -> next cycle state=IDLE, flag=1, no start_stop pulse.
